// File: rtl/seq_det_pkg.sv
// Shared types and encodings for the seq_det_fsm symbol-stream sequence detector.
package seq_det_pkg;

  localparam int STATE_W = 2;

  // Encodings seen by the outside world on state_o.
  localparam logic [STATE_W-1:0] ENC_IDLE = 2'b00;
  localparam logic [STATE_W-1:0] ENC_FILL = 2'b01;
  localparam logic [STATE_W-1:0] ENC_HUNT = 2'b10;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = ENC_IDLE,
    ST_FILL = ENC_FILL,
    ST_HUNT = ENC_HUNT
  } state_t;

  // Bits needed to hold the values 0..max_val.
  function automatic int unsigned count_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/seq_window.sv
// Symbol shift window with saturating fill count; newest symbol in the top slot.
module seq_window
  import seq_det_pkg::*;
#(
  parameter int W     = 2,
  parameter int DEPTH = 3
) (
  input  logic                            clk,
  input  logic                            rst_b,
  input  logic                            shift,
  input  logic                            clear,
  input  logic [W-1:0]                    sym,
  output logic [DEPTH*W-1:0]              window_next,
  output logic [count_width(DEPTH)-1:0]   fill,
  output logic [count_width(DEPTH)-1:0]   fill_next
);

  localparam int                FILL_W    = count_width(DEPTH);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DEPTH);

  logic [DEPTH*W-1:0] window;
  logic [DEPTH*W-1:0] shifted;
  logic               unused_oldest;

  generate
    if (DEPTH == 1) begin : g_single
      assign shifted = sym;
    end else begin : g_multi
      assign shifted = {sym, window[DEPTH*W-1:W]};
    end
  endgenerate

  // The oldest slot only ever falls off the end of the window.
  assign unused_oldest = ^window[W-1:0];

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    window_next = window;
    fill_next   = fill;
    if (shift) begin
      window_next = shifted;
      fill_next   = (fill == FILL_FULL) ? fill : fill + 1'b1;
    end
  end

  // NOTE: the window is a small register bank, not a RAM, so it is safe and required to reset it.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      // NOTE: non-blocking assignments in clocked blocks keep every register sampling pre-edge values.
      window <= '0;
      fill   <= '0;
    end else if (clear) begin
      window <= '0;
      fill   <= '0;
    end else begin
      window <= window_next;
      fill   <= fill_next;
    end
  end

endmodule

// File: rtl/seq_det_fsm.sv
// Parametrised sequence detector: IDLE/FILL/HUNT FSM, latched pattern, hit counter.
// Optional idle timeout is built only when SEQDET_TIMEOUT_EN is defined.
module seq_det_fsm
  import seq_det_pkg::*;
#(
  parameter int W       = 2,
  parameter int DEPTH   = 3,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst_b,
  input  logic                en,
  input  logic                clr,
  input  logic                ovl,
  input  logic                sym_vld,
  input  logic [W-1:0]        sym,
  input  logic [DEPTH*W-1:0]  pat,
  output logic                hit,
  output logic [CNT_W-1:0]    hit_cnt,
  output logic [STATE_W-1:0]  state_o,
  output logic                tmo
);

  localparam int                FILL_W    = count_width(DEPTH);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DEPTH);

  state_t             state;
  state_t             state_next;
  logic [DEPTH*W-1:0] pat_q;
  logic [DEPTH*W-1:0] window_next;
  logic [FILL_W-1:0]  fill;
  logic [FILL_W-1:0]  fill_next;
  logic               accept;
  logic               full_next;
  logic               match;
  logic               leave_idle;
  logic               win_clear;
  logic               timeout;

  assign accept     = en && sym_vld && !clr && (state != ST_IDLE);
  assign full_next  = (fill_next == FILL_FULL);
  assign match      = accept && full_next && (window_next == pat_q);
  assign leave_idle = en && (state == ST_IDLE);

  // Non-overlap restarts from an empty window so the next hit needs DEPTH fresh symbols.
  assign win_clear  = !en || clr || leave_idle || timeout || (match && !ovl);

  seq_window #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_window (
    .clk         (clk),
    .rst_b       (rst_b),
    .shift       (accept),
    .clear       (win_clear),
    .sym         (sym),
    .window_next (window_next),
    .fill        (fill),
    .fill_next   (fill_next)
  );

  always_comb begin
    state_next = state;
    if (!en) begin
      state_next = ST_IDLE;
    end else if (state == ST_IDLE) begin
      state_next = ST_FILL;
    end else if (clr || timeout) begin
      state_next = ST_FILL;
    end else if (accept) begin
      if (match && !ovl)   state_next = ST_FILL;
      else if (full_next)  state_next = ST_HUNT;
      else                 state_next = ST_FILL;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state <= ST_IDLE;
      pat_q <= '0;
      hit   <= 1'b0;
      tmo   <= 1'b0;
    end else begin
      state <= state_next;
      hit   <= match;
      tmo   <= timeout;
      if (leave_idle) pat_q <= pat;
    end
  end

  // Saturates rather than wraps so a long run never reads as a small count.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      hit_cnt <= '0;
    end else if (clr) begin
      hit_cnt <= '0;
    end else if (match && (hit_cnt != '1)) begin
      hit_cnt <= hit_cnt + 1'b1;
    end
  end

  assign state_o = state;

`ifdef SEQDET_TIMEOUT_EN
  localparam int IDLE_W = count_width(TIMEOUT);

  logic [IDLE_W-1:0] idle_cnt;
  logic              counting;

  // Only a partly built window can go stale; an empty one has nothing to drop.
  assign counting = en && !clr && (state != ST_IDLE) && (fill != '0) && !accept;
  assign timeout  = counting && (idle_cnt == IDLE_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      idle_cnt <= '0;
    end else if (counting && !timeout) begin
      idle_cnt <= idle_cnt + 1'b1;
    end else begin
      idle_cnt <= '0;
    end
  end
`else
  logic unused_cfg;

  assign timeout    = 1'b0;
  assign unused_cfg = ^{TIMEOUT, fill};
`endif

endmodule

// File: tb/tb_seq_det_fsm.sv
// Directed scoreboard bench for seq_det_fsm: three instances (DEPTH 3/2/1), one checked per phase.
module tb_seq_det_fsm;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_FILL = 2'b01;
  localparam logic [1:0] S_HUNT = 2'b10;

  logic       clk = 1'b0;
  logic       rst_b, en, clr, ovl, sym_vld;
  logic [1:0] sym;
  logic [5:0] pat3;
  logic [3:0] pat2;
  logic [1:0] pat1;

  logic       hit3, hit2, hit1;
  logic [7:0] cnt3, cnt2;
  logic [1:0] cnt1;
  logic [1:0] st3, st2, st1;
  logic       tmo3, tmo2, tmo1;

  always #5 clk = ~clk;

  seq_det_fsm #(.W(2), .DEPTH(3), .CNT_W(8), .TIMEOUT(4)) u_d3 (
    .clk(clk), .rst_b(rst_b), .en(en), .clr(clr), .ovl(ovl), .sym_vld(sym_vld),
    .sym(sym), .pat(pat3), .hit(hit3), .hit_cnt(cnt3), .state_o(st3), .tmo(tmo3));

  seq_det_fsm #(.W(2), .DEPTH(2), .CNT_W(8), .TIMEOUT(16)) u_d2 (
    .clk(clk), .rst_b(rst_b), .en(en), .clr(clr), .ovl(ovl), .sym_vld(sym_vld),
    .sym(sym), .pat(pat2), .hit(hit2), .hit_cnt(cnt2), .state_o(st2), .tmo(tmo2));

  seq_det_fsm #(.W(2), .DEPTH(1), .CNT_W(2), .TIMEOUT(16)) u_d1 (
    .clk(clk), .rst_b(rst_b), .en(en), .clr(clr), .ovl(ovl), .sym_vld(sym_vld),
    .sym(sym), .pat(pat1), .hit(hit1), .hit_cnt(cnt1), .state_o(st1), .tmo(tmo1));

  typedef struct {
    int         sel;
    logic       hit;
    logic [7:0] cnt;
    logic [1:0] st;
    logic       tmo;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   sel    = 3;

  task automatic push_exp(input logic h, input logic [7:0] c, input logic [1:0] s,
                          input logic t, input string tag);
    exp_t e;
    e.sel = sel; e.hit = h; e.cnt = c; e.st = s; e.tmo = t; e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic check();
    exp_t       e;
    logic       oh, ot;
    logic [7:0] oc;
    logic [1:0] os;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty: observed no entry, expected one");
      return;
    end
    e = exp_q.pop_front();
    case (e.sel)
      3:       begin oh = hit3; oc = cnt3;          os = st3; ot = tmo3; end
      2:       begin oh = hit2; oc = cnt2;          os = st2; ot = tmo2; end
      default: begin oh = hit1; oc = {6'd0, cnt1};  os = st1; ot = tmo1; end
    endcase
    checks++;
    assert (oh === e.hit) else begin
      errors++;
      $error("FAIL %s hit: observed %b expected %b", e.tag, oh, e.hit);
    end
    checks++;
    assert (oc === e.cnt) else begin
      errors++;
      $error("FAIL %s hit_cnt: observed %0d expected %0d", e.tag, oc, e.cnt);
    end
    checks++;
    assert (os === e.st) else begin
      errors++;
      $error("FAIL %s state_o: observed %b expected %b", e.tag, os, e.st);
    end
    checks++;
    assert (ot === e.tmo) else begin
      errors++;
      $error("FAIL %s tmo: observed %b expected %b", e.tag, ot, e.tmo);
    end
  endtask

  // One clock of stimulus; outputs sampled 1 time unit after the edge.
  task automatic step(input logic v, input logic [1:0] s, input logic c,
                      input logic h, input logic [7:0] cn, input logic [1:0] st,
                      input logic t, input string tag);
    sym_vld = v;
    sym     = s;
    clr     = c;
    push_exp(h, cn, st, t, tag);
    @(posedge clk);
    #1;
    check();
    sym_vld = 1'b0;
    clr     = 1'b0;
  endtask

  task automatic check_now(input logic h, input logic [7:0] cn, input logic [1:0] st,
                           input string tag);
    push_exp(h, cn, st, 1'b0, tag);
    check();
  endtask

  task automatic pulse_reset();
    en    = 1'b0;
    rst_b = 1'b0;
    #2;
    rst_b = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no end of run, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_b = 1'b1; en = 1'b0; clr = 1'b0; ovl = 1'b0; sym_vld = 1'b0; sym = 2'b00;
    pat3 = 6'b11_01_10;
    pat2 = 4'b01_01;
    pat1 = 2'b11;
    #1 rst_b = 1'b0;
    #2;
    sel = 3; check_now(1'b0, 8'd0, S_IDLE, "reset_d3");
    sel = 2; check_now(1'b0, 8'd0, S_IDLE, "reset_d2");
    sel = 1; check_now(1'b0, 8'd0, S_IDLE, "reset_d1");
    rst_b = 1'b1;

    // Basic non-overlapping match, then a HUNT miss followed by a shifted-in match.
    sel = 3; ovl = 1'b0; en = 1'b1;
    step(0, 2'b00, 0, 0, 8'd0, S_FILL, 0, "t1_enable");
    step(1, 2'b10, 0, 0, 8'd0, S_FILL, 0, "t1_sym1");
    step(1, 2'b01, 0, 0, 8'd0, S_FILL, 0, "t1_sym2");
    step(1, 2'b11, 0, 1, 8'd1, S_FILL, 0, "t1_hit");
    step(0, 2'b00, 0, 0, 8'd1, S_FILL, 0, "t1_hit_drop");
    step(1, 2'b10, 0, 0, 8'd1, S_FILL, 0, "t1b_a");
    step(1, 2'b01, 0, 0, 8'd1, S_FILL, 0, "t1b_b");
    step(1, 2'b10, 0, 0, 8'd1, S_HUNT, 0, "t1b_miss");
    step(1, 2'b01, 0, 0, 8'd1, S_HUNT, 0, "t1b_hunt");
    step(1, 2'b11, 0, 1, 8'd2, S_FILL, 0, "t1b_hit");

    // clr beats a completing symbol; async reset mid-window.
    pulse_reset();
    en = 1'b1;
    step(0, 2'b00, 0, 0, 8'd0, S_FILL, 0, "t4_enable");
    step(1, 2'b10, 0, 0, 8'd0, S_FILL, 0, "t4_a");
    step(1, 2'b01, 0, 0, 8'd0, S_FILL, 0, "t4_b");
    step(1, 2'b11, 0, 1, 8'd1, S_FILL, 0, "t4_hit");
    step(1, 2'b10, 0, 0, 8'd1, S_FILL, 0, "t4_c");
    step(1, 2'b01, 0, 0, 8'd1, S_FILL, 0, "t4_d");
    step(1, 2'b11, 1, 0, 8'd0, S_FILL, 0, "t4_clr_wins");
    step(0, 2'b00, 0, 0, 8'd0, S_FILL, 0, "t4_after_clr");
    step(1, 2'b10, 0, 0, 8'd0, S_FILL, 0, "t4_e");
    step(1, 2'b01, 0, 0, 8'd0, S_FILL, 0, "t4_f");
    step(1, 2'b11, 0, 1, 8'd1, S_FILL, 0, "t4_hit2");
    step(1, 2'b10, 0, 0, 8'd1, S_FILL, 0, "t4_g");
    step(1, 2'b01, 0, 0, 8'd1, S_FILL, 0, "t4_h");
    rst_b = 1'b0;
    #2;
    check_now(1'b0, 8'd0, S_IDLE, "t4_async_reset");
    rst_b = 1'b1;
    step(0, 2'b00, 0, 0, 8'd0, S_FILL, 0, "t4_reenable");
    step(1, 2'b11, 0, 0, 8'd0, S_FILL, 0, "t4_lone_last");
    step(1, 2'b10, 0, 0, 8'd0, S_FILL, 0, "t4_i");
    step(1, 2'b01, 0, 0, 8'd0, S_HUNT, 0, "t4_j");
    step(1, 2'b11, 0, 1, 8'd1, S_FILL, 0, "t4_hit3");

    // en gap between 2nd and 3rd symbols.
    pulse_reset();
    en = 1'b1;
    step(0, 2'b00, 0, 0, 8'd0, S_FILL, 0, "t5_enable");
    step(1, 2'b10, 0, 0, 8'd0, S_FILL, 0, "t5_a");
    step(1, 2'b01, 0, 0, 8'd0, S_FILL, 0, "t5_b");
    step(1, 2'b11, 0, 1, 8'd1, S_FILL, 0, "t5_hit");
    step(1, 2'b10, 0, 0, 8'd1, S_FILL, 0, "t5_c");
    step(1, 2'b01, 0, 0, 8'd1, S_FILL, 0, "t5_d");
    en = 1'b0;
    step(0, 2'b00, 0, 0, 8'd1, S_IDLE, 0, "t5_en_low");
    en = 1'b1;
    step(1, 2'b11, 0, 0, 8'd1, S_FILL, 0, "t5_ignored");
    step(1, 2'b10, 0, 0, 8'd1, S_FILL, 0, "t5_e");
    step(1, 2'b01, 0, 0, 8'd1, S_FILL, 0, "t5_f");
    step(1, 2'b11, 0, 1, 8'd2, S_FILL, 0, "t5_hit2");

    // DEPTH=2 pattern 01_01: overlapping then non-overlapping.
    pulse_reset();
    sel = 2; ovl = 1'b1; en = 1'b1;
    step(0, 2'b00, 0, 0, 8'd0, S_FILL, 0, "t2_enable");
    step(1, 2'b01, 0, 0, 8'd0, S_FILL, 0, "t2o_a");
    step(1, 2'b01, 0, 1, 8'd1, S_HUNT, 0, "t2o_hit1");
    step(1, 2'b01, 0, 1, 8'd2, S_HUNT, 0, "t2o_hit2");
    step(0, 2'b00, 0, 0, 8'd2, S_HUNT, 0, "t2o_idle");
    step(0, 2'b00, 1, 0, 8'd0, S_FILL, 0, "t2_clr");
    ovl = 1'b0;
    step(1, 2'b01, 0, 0, 8'd0, S_FILL, 0, "t2n_a");
    step(1, 2'b01, 0, 1, 8'd1, S_FILL, 0, "t2n_hit");
    step(1, 2'b01, 0, 0, 8'd1, S_FILL, 0, "t2n_nohit");
    step(0, 2'b00, 0, 0, 8'd1, S_FILL, 0, "t2n_idle");

    // DEPTH=1, CNT_W=2: saturation at 3 with hit still pulsing.
    pulse_reset();
    sel = 1; ovl = 1'b0; en = 1'b1;
    step(0, 2'b00, 0, 0, 8'd0, S_FILL, 0, "t3_enable");
    step(1, 2'b11, 0, 1, 8'd1, S_FILL, 0, "t3_hit1");
    step(1, 2'b11, 0, 1, 8'd2, S_FILL, 0, "t3_hit2");
    step(1, 2'b11, 0, 1, 8'd3, S_FILL, 0, "t3_hit3");
    step(1, 2'b11, 0, 1, 8'd3, S_FILL, 0, "t3_sat4");
    step(1, 2'b11, 0, 1, 8'd3, S_FILL, 0, "t3_sat5");
    step(1, 2'b01, 0, 0, 8'd3, S_HUNT, 0, "t3_miss");
    step(1, 2'b11, 0, 1, 8'd3, S_FILL, 0, "t3_hit6");

`ifdef SEQDET_TIMEOUT_EN
    // Idle timeout drops a partial window after TIMEOUT=4 idle cycles.
    pulse_reset();
    sel = 3; ovl = 1'b0; en = 1'b1;
    step(0, 2'b00, 0, 0, 8'd0, S_FILL, 0, "t6_enable");
    step(1, 2'b10, 0, 0, 8'd0, S_FILL, 0, "t6_a");
    step(1, 2'b01, 0, 0, 8'd0, S_FILL, 0, "t6_b");
    step(0, 2'b00, 0, 0, 8'd0, S_FILL, 0, "t6_idle1");
    step(0, 2'b00, 0, 0, 8'd0, S_FILL, 0, "t6_idle2");
    step(0, 2'b00, 0, 0, 8'd0, S_FILL, 0, "t6_idle3");
    step(0, 2'b00, 0, 0, 8'd0, S_FILL, 1, "t6_tmo");
    step(1, 2'b11, 0, 0, 8'd0, S_FILL, 0, "t6_stale");
    step(1, 2'b10, 0, 0, 8'd0, S_FILL, 0, "t6_c");
    step(1, 2'b01, 0, 0, 8'd0, S_HUNT, 0, "t6_d");
    step(1, 2'b11, 0, 1, 8'd1, S_FILL, 0, "t6_hit");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
